// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by the receiver and the
// transmitter FSM.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_START  = 7;
    localparam int SAMPLE_PT  = 15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so reset release never looks like a start bit.
module uart_sync2 (
    input  logic bot_clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge bot_clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver sampling at 16x baud with a 3-sample majority vote per bit.
//   state | meaning
//   IDLE  | line high, waiting for a start edge
//   START | confirming the start bit at its midpoint
//   DATA  | shifting in DATA_BITS data bits, LSB first
//   STOP  | checking the stop bit
//   BREAK | stop bit was low; waiting for the line to return high
module uart_receiver (
    input  logic                           bot_clk,
    input  logic                           reset,
    input  logic                           uart_rx,
    output logic [uart_pkg::DATA_BITS-1:0] rx_data,
    output logic                           rx_status,
    output logic                           frame_err,
    output logic                           rx_busy
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID_START);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] CNT_V1     = CNT_W'(SAMPLE_PT - 2);
    localparam logic [CNT_W-1:0] CNT_V2     = CNT_W'(SAMPLE_PT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

    uart_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   samp_1;
    logic                   samp_2;
    logic                   rxs;
    logic                   vote;

    uart_sync2 u_sync (
        .bot_clk (bot_clk),
        .reset   (reset),
        .din     (uart_rx),
        .dout    (rxs)
    );

    // The third vote sample is the live synchronized line at SAMPLE_PT.
    assign vote = majority3(samp_1, samp_2, rxs);

    always_ff @(posedge bot_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            samp_1    <= 1'b1;
            samp_2    <= 1'b1;
            rx_data   <= '0;
            rx_status <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_status <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (cnt == CNT_V1) samp_1 <= rxs;
            if (cnt == CNT_V2) samp_2 <= rxs;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    // cnt wraps to 0 here, so STOP starts on a fresh bit window.
                    if (cnt == CNT_SAMPLE) begin
                        shift <= {vote, shift[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == CNT_SAMPLE) begin
                        if (vote) begin
                            rx_data   <= shift;
                            rx_status <= 1'b1;
                            state     <= IDLE;
                            rx_busy   <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed table of frames, hand sequences for the
// glitch and reset corners, then random frames against a byte-level model.
module tb_uart_receiver;

    localparam int BIT_T = 16;
    localparam int LAT   = 154;

    logic       bot_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       rx_busy;

    uart_receiver dut (
        .bot_clk   (bot_clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 bot_clk = ~bot_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pcyc  = 0;

    always @(posedge bot_clk) pcyc <= pcyc + 1;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         extra_low;
        int         gap;
        logic [7:0] gmask;
        int         goff;
        logic       exp_err;
        logic [7:0] exp_data;
    } row_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    logic prev_stb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, pcyc);
        end
    endtask

    // Strobe monitor: records every rx_status / frame_err with its cycle.
    always @(negedge bot_clk) begin
        if (reset) begin
            if (rx_status || frame_err) begin
                check("strobe_exclusive", 32'(rx_status & frame_err), 32'd0);
                check("strobe_single_cycle", 32'(prev_stb), 32'd0);
                obs_q.push_back('{pcyc, frame_err, rx_data});
            end
            prev_stb = rx_status | frame_err;
        end else begin
            prev_stb = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", pcyc);
        $fatal(1, "watchdog");
    end

    // Called 1ns after a posedge; drives v for n sampling edges.
    task automatic hold(input logic v, input int n);
        if (n > 0) begin
            uart_rx = v;
            repeat (n) @(posedge bot_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low,
                              input int gap, input logic [7:0] gmask, input int goff,
                              output int start);
        start = pcyc + 1;
        hold(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) begin
            if (gmask[i]) begin
                hold(d[i], goff);
                hold(~d[i], 1);
                hold(d[i], BIT_T - goff - 1);
            end else begin
                hold(d[i], BIT_T);
            end
        end
        hold(stop, BIT_T + extra_low);
        hold(1'b1, gap);
    endtask

    task automatic wait_pcyc(input int target);
        while (pcyc < target) @(negedge bot_clk);
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_kind"},  32'(obs_q[i].err),  32'(exp_q[i].err));
            check({tag, "_data"},  32'(obs_q[i].data), 32'(exp_q[i].data));
            check({tag, "_cycle"}, obs_q[i].cyc,       exp_q[i].cyc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] d, input logic busy);
        check({tag, "_rx_data"},   32'(rx_data),   32'(d));
        check({tag, "_rx_status"}, 32'(rx_status), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_rx_busy"},   32'(rx_busy),   32'(busy));
    endtask

    initial begin
        row_t       tbl[5];
        int         s0;
        int         st;
        logic [7:0] model_data;
        logic [7:0] rd;
        logic       rstop;
        int         rgap;
        logic [7:0] rmask;
        int         roff;

        tbl[0] = '{8'h3C, 1'b0, 300, 20, 8'h00, 0, 1'b1, 8'hA5};
        tbl[1] = '{8'h81, 1'b1, 0,   10, 8'h00, 0, 1'b0, 8'h81};
        tbl[2] = '{8'h00, 1'b1, 0,   0,  8'hFF, 6, 1'b0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 0,   0,  8'hFF, 6, 1'b0, 8'hFF};
        tbl[4] = '{8'h55, 1'b1, 0,   20, 8'hFF, 6, 1'b0, 8'h55};

        // Reset and idle line
        repeat (3) @(posedge bot_clk);
        #1;
        check_outputs("in_reset", 8'h00, 1'b0);
        reset = 1'b1;
        hold(1'b1, 100);
        check_outputs("idle", 8'h00, 1'b0);
        check_events("idle");

        // 0xA5 with latency and busy window
        s0 = pcyc + 1;
        fork
            send_frame(8'hA5, 1'b1, 0, 20, 8'h00, 0, st);
            begin
                wait_pcyc(s0 + 1);   check("a5_busy_before", 32'(rx_busy), 32'd0);
                wait_pcyc(s0 + 2);   check("a5_busy_rise",   32'(rx_busy), 32'd1);
                wait_pcyc(s0 + 80);  check("a5_busy_mid",    32'(rx_busy), 32'd1);
                wait_pcyc(s0 + 153); check("a5_busy_last",   32'(rx_busy), 32'd1);
                wait_pcyc(s0 + 154); check("a5_busy_fall",   32'(rx_busy), 32'd0);
            end
        join
        exp_q.push_back('{s0 + LAT, 1'b0, 8'hA5});
        check_events("a5");
        model_data = 8'hA5;

        // 3-cycle low glitch: rejected at the start-bit midpoint
        s0 = pcyc + 1;
        fork
            begin
                hold(1'b0, 3);
                hold(1'b1, 40);
            end
            begin
                wait_pcyc(s0 + 9);  check("glitch_busy_hi", 32'(rx_busy), 32'd1);
                wait_pcyc(s0 + 10); check("glitch_busy_lo", 32'(rx_busy), 32'd0);
            end
        join
        check_events("glitch");
        check("glitch_rx_data", 32'(rx_data), 32'(model_data));

        // Directed table: break, recovery, back-to-back with vote glitches
        for (int k = 0; k < 5; k++) begin
            send_frame(tbl[k].d, tbl[k].stop, tbl[k].extra_low, tbl[k].gap,
                       tbl[k].gmask, tbl[k].goff, st);
            exp_q.push_back('{st + LAT, tbl[k].exp_err, tbl[k].exp_data});
        end
        check_events("table");
        model_data = 8'h55;
        check("table_rx_data", 32'(rx_data), 32'(model_data));

        // Random frames against the byte-level model
        for (int k = 0; k < 25; k++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            rgap  = rstop ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 12));
            rmask = 8'($urandom_range(0, 255));
            roff  = int'($urandom_range(1, 14));
            send_frame(rd, rstop, 0, rgap, rmask, roff, st);
            if (rstop) model_data = rd;
            exp_q.push_back('{st + LAT, !rstop, model_data});
        end
        hold(1'b1, 20);
        check_events("random");
        check("random_rx_data", 32'(rx_data), 32'(model_data));

        // Reset mid-DATA of 0x12, then a fresh 0x34
        hold(1'b0, BIT_T);
        hold(1'b0, BIT_T);
        hold(1'b1, BIT_T);
        hold(1'b0, 10);
        reset = 1'b0;
        #1;
        check_outputs("mid_reset", 8'h00, 1'b0);
        uart_rx = 1'b1;
        repeat (3) @(posedge bot_clk);
        #1;
        reset = 1'b1;
        hold(1'b1, 20);
        check_events("aborted");
        send_frame(8'h34, 1'b1, 0, 20, 8'h00, 0, st);
        exp_q.push_back('{st + LAT, 1'b0, 8'h34});
        check_events("after_reset");
        check("after_reset_rx_data", 32'(rx_data), 32'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
